// File: rtl/regfile_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_param_if
//  Description : Bundle of write, read, scoreboard and clear signals for the
//                parameterised register file. The master drives requests and
//                the slave (the register file) returns read data and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_param_if #(
    parameter int DW  = 32,
    parameter int AW  = 4,
    parameter int NRD = 3
);
    logic                  we3;
    logic [AW-1:0]         wa3;
    logic [DW-1:0]         wd3;
    logic [DW/8-1:0]       wbe;
    logic [NRD*AW-1:0]     ra;
    logic [DW-1:0]         pc_in;
    logic                  clr;
    logic                  pend_set;
    logic [AW-1:0]         pend_addr;
    logic [NRD*DW-1:0]     rd;
    logic [NRD-1:0]        rd_pend;
    logic                  busy;

    modport master (
        output we3, wa3, wd3, wbe, ra, pc_in, clr, pend_set, pend_addr,
        input  rd, rd_pend, busy
    );

    modport slave (
        input  we3, wa3, wd3, wbe, ra, pc_in, clr, pend_set, pend_addr,
        output rd, rd_pend, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_param
//  Description : Multi-port register file with byte-enabled writes, write-to-
//                read bypass, a PC alias at the top index, a per-register
//                pending scoreboard and a run-time zeroing sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_param #(
    parameter int DW  = 32,
    parameter int AW  = 4,
    parameter int NRD = 3
) (
    input  logic              clk,
    input  logic              reset,
    regfile_param_if.slave    bus
);
    localparam int            DEPTH    = 2**AW;
    localparam int            NB       = DW/8;
    localparam logic [AW-1:0] TOP_IDX  = AW'(DEPTH-1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-2);

    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_CLEAR  = 1'b1;

    logic [0:0]     r_state;
    logic [AW-1:0]  r_cnt;
    logic [DW-1:0]  r_mem [0:DEPTH-2];
    logic [DEPTH-2:0] r_pend;
    logic [DW-1:0]  r_rd [NRD];
    logic [NRD-1:0] r_rd_pend;

    logic             w_busy;
    logic             w_wr;
    logic [DW-1:0]    w_old;
    logic [DW-1:0]    w_merged;
    logic [DEPTH-2:0] w_pend_next;

    assign w_busy = (r_state == S_CLEAR);
    // A write only lands when idle and not aimed at the PC alias
    assign w_wr   = bus.we3 && !w_busy && (bus.wa3 != TOP_IDX);

    // Merge enabled bytes of the write data over the current register value
    always_comb begin
        w_old    = (bus.wa3 == TOP_IDX) ? '0 : r_mem[bus.wa3];
        w_merged = w_old;
        for (int k = 0; k < NB; k++) begin
            if (bus.wbe[k]) begin
                w_merged[8*k +: 8] = bus.wd3[8*k +: 8];
            end
        end
    end

    // Next pending vector: the sweep clears one bit, otherwise write clears and set wins
    always_comb begin
        w_pend_next = r_pend;
        if (w_busy) begin
            w_pend_next[r_cnt] = 1'b0;
        end else begin
            if (w_wr) begin
                w_pend_next[bus.wa3] = 1'b0;
            end
            if (bus.pend_set && (bus.pend_addr != TOP_IDX)) begin
                w_pend_next[bus.pend_addr] = 1'b1;
            end
        end
    end

    // Sweep controller: reset or clr starts a sweep from entry 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.clr) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= S_IDLE;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Pending scoreboard
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // Storage: the sweep zeroes one entry per cycle, otherwise normal writes
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_busy) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr) begin
                r_mem[bus.wa3] <= w_merged;
            end
        end
    end

    // Registered read ports with PC alias and same-cycle write bypass
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NRD; i++) begin
                r_rd[i] <= '0;
            end
            r_rd_pend <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (bus.ra[i*AW +: AW] == TOP_IDX) begin
                    r_rd[i]      <= bus.pc_in;
                    r_rd_pend[i] <= 1'b0;
                end else if (w_busy) begin
                    r_rd[i]      <= '0;
                    r_rd_pend[i] <= 1'b0;
                end else begin
                    if (w_wr && (bus.wa3 == bus.ra[i*AW +: AW])) begin
                        r_rd[i] <= w_merged;
                    end else begin
                        r_rd[i] <= r_mem[bus.ra[i*AW +: AW]];
                    end
                    r_rd_pend[i] <= w_pend_next[bus.ra[i*AW +: AW]];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_port
        assign bus.rd[gi*DW +: DW] = r_rd[gi];
    end

    assign bus.rd_pend = r_rd_pend;
    assign bus.busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_param
//  Description : Scoreboard bench for regfile_param. A driver issues one
//                request per cycle and queues the expected response from an
//                array-based reference model; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_param;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NRD   = 3;
    localparam int NB    = DW/8;
    localparam int DEPTH = 2**AW;
    localparam int TOP   = DEPTH-1;

    typedef struct {
        logic [NRD*DW-1:0] rd;
        logic [NRD-1:0]    pend;
        logic              busy;
    } exp_t;

    logic clk;
    logic reset;
    regfile_param_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    regfile_param #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH-1];
    bit            pend_m [DEPTH-1];
    int            sweep_left;
    int            clear_idx;
    exp_t          q [$];

    int checks   = 0;
    int failures = 0;
    bit done     = 0;

    // One request per cycle; the model computes the state after the next edge
    task automatic step(input logic rst_i, input logic we_i, input int wa_i,
                        input logic [DW-1:0] wd_i, input logic [NB-1:0] be_i,
                        input logic [NRD*AW-1:0] ra_i, input logic [DW-1:0] pc_i,
                        input logic clr_i, input logic ps_i, input int pa_i);
        exp_t e;
        int   a;
        @(negedge clk);
        reset         = rst_i;
        bus.we3       = we_i;
        bus.wa3       = AW'(wa_i);
        bus.wd3       = wd_i;
        bus.wbe       = be_i;
        bus.ra        = ra_i;
        bus.pc_in     = pc_i;
        bus.clr       = clr_i;
        bus.pend_set  = ps_i;
        bus.pend_addr = AW'(pa_i);
        e.rd   = '0;
        e.pend = '0;
        if (rst_i) begin
            sweep_left = DEPTH-1;
            clear_idx  = 0;
        end else if (sweep_left > 0) begin
            mem_m[clear_idx]  = '0;
            pend_m[clear_idx] = 0;
            clear_idx++;
            sweep_left--;
            for (int i = 0; i < NRD; i++) begin
                a = int'(ra_i[i*AW +: AW]);
                e.rd[i*DW +: DW] = (a == TOP) ? pc_i : '0;
            end
        end else begin
            if (we_i && wa_i != TOP) begin
                for (int k = 0; k < NB; k++)
                    if (be_i[k]) mem_m[wa_i][8*k +: 8] = wd_i[8*k +: 8];
                pend_m[wa_i] = 0;
            end
            if (ps_i && pa_i != TOP) pend_m[pa_i] = 1;
            for (int i = 0; i < NRD; i++) begin
                a = int'(ra_i[i*AW +: AW]);
                e.rd[i*DW +: DW] = (a == TOP) ? pc_i : mem_m[a];
                e.pend[i]        = (a == TOP) ? 1'b0 : pend_m[a];
            end
            if (clr_i) begin
                sweep_left = DEPTH-1;
                clear_idx  = 0;
            end
        end
        e.busy = (sweep_left > 0);
        q.push_back(e);
    endtask

    function automatic logic [NRD*AW-1:0] all_ports(input int a);
        logic [NRD*AW-1:0] r;
        for (int i = 0; i < NRD; i++) r[i*AW +: AW] = AW'(a);
        return r;
    endfunction

    task automatic write(input int wa, input logic [DW-1:0] wd, input logic [NB-1:0] be,
                         input int ra, input logic ps, input int pa);
        step(0, 1, wa, wd, be, all_ports(ra), 32'h0000_1008, 0, ps, pa);
    endtask

    task automatic rd_only(input int ra);
        step(0, 0, 0, '0, '0, all_ports(ra), 32'h0000_1008, 0, 0, 0);
    endtask

    // Monitor: compare every queued expectation just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.rd !== e.rd) begin
                    failures++;
                    $display("FAIL rd: got %h expected %h at %0t", bus.rd, e.rd, $time);
                end
                checks++;
                if (bus.rd_pend !== e.pend) begin
                    failures++;
                    $display("FAIL rd_pend: got %b expected %b at %0t", bus.rd_pend, e.pend, $time);
                end
                checks++;
                if (bus.busy !== e.busy) begin
                    failures++;
                    $display("FAIL busy: got %b expected %b at %0t", bus.busy, e.busy, $time);
                end
            end
        end
    end

    initial begin
        logic [NRD*AW-1:0] ra_r;
        int wa_r;
        for (int i = 0; i < DEPTH-1; i++) begin
            mem_m[i]  = '0;
            pend_m[i] = 0;
        end
        sweep_left = 0;
        clear_idx  = 0;
        reset = 1'b1;
        bus.we3 = 0; bus.wa3 = '0; bus.wd3 = '0; bus.wbe = '0; bus.ra = '0;
        bus.pc_in = '0; bus.clr = 0; bus.pend_set = 0; bus.pend_addr = '0;

        // Reset with competing requests; reset must dominate
        step(1, 1, 3, 32'hDEAD_BEEF, 4'hF, all_ports(3), 32'h0, 1, 1, 3);
        step(1, 0, 0, '0, '0, all_ports(0), 32'h0, 0, 0, 0);
        // Sweep after reset, with ignored writes/sets/clr in the middle
        for (int c = 0; c < DEPTH-1; c++)
            step(0, 1, c % TOP, $urandom, 4'hF, all_ports(c), 32'h0000_1008,
                 (c == 4), 1, c % TOP);
        for (int a = 0; a < DEPTH; a++) rd_only(a);
        rd_only(TOP);

        // Byte-enabled write with same-cycle bypass, then a later read
        write(3, 32'h1122_3344, 4'hF, 0, 0, 0);
        write(3, 32'hAABB_CCDD, 4'b0101, 3, 0, 0);
        rd_only(3);

        // Pending set, then a zero-byte-enable write clears it
        step(0, 0, 0, '0, '0, all_ports(5), 32'h0000_1008, 0, 1, 5);
        rd_only(5);
        write(5, 32'hFFFF_FFFF, 4'b0000, 5, 0, 0);
        rd_only(5);

        // Same-cycle set and write: set wins, data lands
        write(7, 32'hCAFE_F00D, 4'hF, 7, 1, 7);
        rd_only(7);
        step(0, 0, 0, '0, '0, all_ports(0), 32'h0, 0, 1, TOP);
        rd_only(TOP);

        // clr sweep with writes ignored while busy
        write(2, 32'h5, 4'hF, 2, 0, 0);
        step(0, 0, 0, '0, '0, all_ports(2), 32'h0000_1008, 1, 0, 0);
        for (int c = 0; c < DEPTH-1; c++) write(4, 32'h1234_5678, 4'hF, (c % 2) ? 4 : TOP, 1, 4);
        rd_only(2);
        rd_only(4);

        // Reset in the middle of a sweep restarts it
        step(0, 0, 0, '0, '0, all_ports(0), 32'h0, 1, 0, 0);
        for (int c = 0; c < 6; c++) rd_only(c);
        step(1, 0, 0, '0, '0, all_ports(0), 32'h0, 0, 0, 0);
        for (int c = 0; c < DEPTH; c++) rd_only(c);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            wa_r = $urandom_range(0, TOP);
            for (int i = 0; i < NRD; i++)
                ra_r[i*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'(wa_r) : AW'($urandom_range(0, TOP));
            step(($urandom_range(0, 299) == 0), $urandom_range(0, 1), wa_r, $urandom,
                 NB'($urandom), ra_r, $urandom, ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1) ? wa_r : $urandom_range(0, TOP));
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DW, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 4: address width; DEPTH = 2**AW entries; index DEPTH-1 is the PC alias.
REQ-003 Parameter NRD, default 3: number of read ports, 1..4.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 reset  in  1: synchronous, active-high.
REQ-006 we3  in  1: write enable (RegWrite).
REQ-007 wa3  in  AW: write address.
REQ-008 wd3  in  DW: write data.
REQ-009 wbe  in  DW/8: byte enables for the write; bit k gates wd3[8k+7:8k].
REQ-010 ra  in  NRD*AW: packed read addresses; port i at [i*AW +: AW].
REQ-011 pc_in  in  DW: value returned for reads of index DEPTH-1 (PC+8 supplied by datapath).
REQ-012 clr  in  1: request a full zeroing sweep at run time.
REQ-013 pend_set  in  1, pend_addr  in  AW: mark register pend_addr as pending (outstanding load).
REQ-014 rd  out  NRD*DW: packed registered read data; port i at [i*DW +: DW].
REQ-015 rd_pend  out  NRD: registered pending flag for the register read on port i.
REQ-016 busy  out  1: high while a clear sweep is in progress.

Function
REQ-017 Storage SHALL be DEPTH-1 entries of DW bits (indices 0..DEPTH-2); index DEPTH-1 has no storage.
REQ-018 Write: on a rising edge with we3=1, busy=0, wa3 != DEPTH-1, each byte k with wbe[k]=1 SHALL take wd3 byte k; others unchanged.
REQ-019 Writes to wa3 = DEPTH-1 SHALL be ignored with no side effect.
REQ-020 Read latency SHALL be exactly 1 cycle: rd port i after edge N reflects ra port i sampled at edge N.
REQ-021 Read of index DEPTH-1 SHALL return pc_in sampled at the same edge.
REQ-022 Bypass: when a qualifying write (REQ-018) targets the same address as read port i in the same cycle, port i SHALL return the post-write merged value (new bytes where wbe=1, old bytes elsewhere).
REQ-023 All NRD ports SHALL operate independently; identical addresses on several ports SHALL return identical data.
REQ-024 Scoreboard: one pending bit per storage entry; pend_set sets bit pend_addr; a qualifying write to wa3 clears bit wa3 regardless of wbe.
REQ-025 Same-cycle pend_set and qualifying write to the same address: set SHALL win (bit ends 1).
REQ-026 pend_set with pend_addr = DEPTH-1 SHALL be ignored; rd_pend for index DEPTH-1 SHALL be 0.
REQ-027 rd_pend[i] SHALL follow REQ-020 timing and reflect the pending bit after that edge's update (bypass-consistent with REQ-024/025).
REQ-028 FSM states IDLE and CLEAR; IDLE->CLEAR on clr=1; CLEAR writes zero to entry cnt and clears its pending bit, cnt increments from 0; CLEAR->IDLE on the edge writing entry DEPTH-2.
REQ-029 A clear sweep SHALL take exactly DEPTH-1 cycles; busy=1 exactly during those cycles.
REQ-030 While busy=1: we3 and pend_set SHALL be ignored; clr SHALL be ignored (no restart); rd SHALL return 0 for storage indices, pc_in for DEPTH-1; rd_pend SHALL be 0.

Reset
REQ-031 reset=1 at an edge SHALL force state CLEAR, cnt=0, rd=0, rd_pend=0, busy=1, regardless of current state or an in-progress sweep (sweep restarts).
REQ-032 After reset deasserts, busy SHALL drop after DEPTH-1 further edges; every entry then reads 0 and no pending bit is set.
REQ-033 reset SHALL take priority over clr, we3 and pend_set in the same cycle.

Verification
REQ-034 Reset, wait busy=0, read all indices 0..14 on every port -> 0; index 15 with pc_in=0x0000_1008 -> 0x0000_1008 one cycle later.
REQ-035 we3=1, wa3=3, wd3=0xAABBCCDD, wbe=4'b0101 over prior 0x11223344, ra port0=3 same cycle -> rd0=0x11BB33DD next cycle; later read also 0x11BB33DD.
REQ-036 pend_set with pend_addr=5, read r5 -> rd_pend=1; then we3 to r5 with wbe=0 -> rd_pend=0, data unchanged.
REQ-037 Same cycle pend_set addr 7 and we3 wa3=7 -> r7 holds wd3, rd_pend for r7 = 1.
REQ-038 Write r2=0x5, pulse clr, assert we3 to r4 during busy -> busy high 15 cycles, afterwards r2=0 and r4=0.
REQ-039 Assert reset at sweep cycle 6 -> busy stays high, sweep restarts from cnt=0, busy drops 15 cycles after reset deasserts.
